router_inject_ni: RTL and testbench

- Injection-side network interface that sits directly upstream of one router input port.
- Takes packet beats from the local core over a valid/ready stream and frames them into 68-bit router channel flits (head/tail/VC/destination).
- Enforces credit-based flow control per VC, using the 2-bit flow-control word the router returns.
- Output drives one 68-bit slice of the router's channel_in_ip; the router's matching 2-bit flow_ctrl_out_ip slice feeds flow_ctrl_in.

---
 rtl/router_inject_ni.sv | 85 ++++++++
 tb/tb_router_inject_ni.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/router_inject_ni.sv
// Injection network interface: frames core beats into 68-bit router flits
// with per-VC credit-based flow control driven by the router's credit return.
module router_inject_ni #(
  parameter int BUF_DEPTH   = 8,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [0:61] tx_data,
  input  logic        tx_last,
  input  logic [0:1]  tx_dest,
  input  logic        tx_vc,
  output logic [0:67] channel_out,
  input  logic [0:1]  flow_ctrl_in,
  output logic        busy,
  output logic        error
);

  typedef enum logic {IDLE, BODY} state_t;

  state_t      state;
  logic        cur_vc;
  logic [4:0]  beat_cnt;
  logic [3:0]  credit [2];

  logic        sel_vc;
  logic        accept;
  logic        head;
  logic        tail;
  logic        force_tail;
  logic [4:0]  cnt_nxt;
  logic [1:0]  send;
  logic [1:0]  ret;

  always_comb begin
    head       = (state == IDLE);
    sel_vc     = head ? tx_vc : cur_vc;
    // Gated by reset so the core sees no ready while credits are being restored
    tx_ready   = !reset && (credit[sel_vc] != '0);
    accept     = tx_valid && tx_ready;
    cnt_nxt    = head ? 5'd1 : beat_cnt + 5'd1;
    force_tail = !tx_last && (cnt_nxt == 5'(MAX_PKT_LEN));
    tail       = tx_last || force_tail;
    send       = '0;
    ret        = '0;
    for (int unsigned v = 0; v < 2; v++) begin
      send[v] = accept && (sel_vc == v[0]);
      ret[v]  = flow_ctrl_in[0] && (flow_ctrl_in[1] == v[0]);
    end
  end

  assign busy = (state == BODY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur_vc      <= 1'b0;
      beat_cnt    <= '0;
      channel_out <= '0;
      error       <= 1'b0;
      for (int unsigned v = 0; v < 2; v++) credit[v] <= 4'(BUF_DEPTH);
    end else begin
      channel_out <= '0;
      if (accept) begin
        channel_out <= {1'b1, head, tail, sel_vc, (head ? tx_dest : 2'b00), tx_data};
        beat_cnt    <= cnt_nxt;
        if (head) cur_vc <= tx_vc;
        state <= tail ? IDLE : BODY;
        if (force_tail) error <= 1'b1;
      end
      // A send and a return on the same VC cancel, so no overflow check applies
      for (int unsigned v = 0; v < 2; v++) begin
        if (send[v] && !ret[v]) begin
          credit[v] <= credit[v] - 4'd1;
        end else if (ret[v] && !send[v]) begin
          if (credit[v] == 4'(BUF_DEPTH)) error <= 1'b1;
          else credit[v] <= credit[v] + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_inject_ni.sv
// Directed self-checking bench for router_inject_ni (framing, credits,
// forced tail on overlong packets, reset mid-packet).
module tb_router_inject_ni;

  logic        clk;
  logic        reset;
  logic        tx_valid;
  logic        tx_ready;
  logic [0:61] tx_data;
  logic        tx_last;
  logic [0:1]  tx_dest;
  logic        tx_vc;
  logic [0:67] channel_out;
  logic [0:1]  flow_ctrl_in;
  logic        busy;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  router_inject_ni #(.BUF_DEPTH(8), .MAX_PKT_LEN(8)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last), .tx_dest(tx_dest), .tx_vc(tx_vc),
    .channel_out(channel_out), .flow_ctrl_in(flow_ctrl_in),
    .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [67:0] flit(input logic h, input logic t, input logic vc,
                                       input logic [1:0] dest, input logic [61:0] d);
    return {1'b1, h, t, vc, dest, d};
  endfunction

  // Present one beat (plus optional credit return), check ready, clock it in.
  task automatic beat(input logic [61:0] d, input logic last, input logic [1:0] dest,
                      input logic vc, input logic [1:0] fc, input logic exp_rdy);
    tx_valid = 1'b1; tx_data = d; tx_last = last; tx_dest = dest; tx_vc = vc;
    flow_ctrl_in = fc;
    #1 check("ready", 68'(tx_ready), 68'(exp_rdy));
    @(posedge clk); #1;
    tx_valid = 1'b0; flow_ctrl_in = 2'b00;
  endtask

  task automatic idle_cycle(input logic [1:0] fc);
    tx_valid = 1'b0; flow_ctrl_in = fc;
    @(posedge clk); #1;
    flow_ctrl_in = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1; tx_valid = 1'b0; flow_ctrl_in = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tx_valid = 1'b1; tx_data = '0; tx_last = 1'b0;
    tx_dest = 2'b00; tx_vc = 1'b0; flow_ctrl_in = 2'b00;
    @(posedge clk); #1;
    check("rst_ready", 68'(tx_ready), 68'd0);
    check("rst_chan", channel_out, 68'd0);
    check("rst_busy", 68'(busy), 68'd0);
    check("rst_error", 68'(error), 68'd0);
    check("rst_cred0", 68'(dut.credit[0]), 68'd8);
    check("rst_cred1", 68'(dut.credit[1]), 68'd8);
    tx_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single-flit packet
    beat(62'h1, 1'b1, 2'b10, 1'b1, 2'b00, 1'b1);
    check("single_flit", channel_out, flit(1'b1, 1'b1, 1'b1, 2'b10, 62'h1));
    check("single_cred1", 68'(dut.credit[1]), 68'd7);
    check("single_busy", 68'(busy), 68'd0);
    idle_cycle(2'b00);
    check("single_clear", channel_out, 68'd0);

    // 4-beat packet on VC0, dest 3; tx_vc/tx_dest changed mid-packet are ignored
    beat(62'hA0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1);
    check("p4_head", channel_out, flit(1'b1, 1'b0, 1'b0, 2'b11, 62'hA0));
    check("p4_busy_h", 68'(busy), 68'd1);
    beat(62'hA1, 1'b0, 2'b01, 1'b1, 2'b00, 1'b1);
    check("p4_body1", channel_out, flit(1'b0, 1'b0, 1'b0, 2'b00, 62'hA1));
    check("p4_busy_b1", 68'(busy), 68'd1);
    beat(62'hA2, 1'b0, 2'b01, 1'b1, 2'b00, 1'b1);
    check("p4_body2", channel_out, flit(1'b0, 1'b0, 1'b0, 2'b00, 62'hA2));
    beat(62'hA3, 1'b1, 2'b10, 1'b1, 2'b00, 1'b1);
    check("p4_tail", channel_out, flit(1'b0, 1'b1, 1'b0, 2'b00, 62'hA3));
    check("p4_busy_t", 68'(busy), 68'd0);
    check("p4_cred0", 68'(dut.credit[0]), 68'd4);
    idle_cycle(2'b00);
    check("p4_clear", channel_out, 68'd0);

    // Credit exhaustion on VC0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      beat(62'(16 + i), 1'b1, 2'b00, 1'b0, 2'b00, 1'b1);
      check("exh_flit", channel_out, flit(1'b1, 1'b1, 1'b0, 2'b00, 62'(16 + i)));
    end
    check("exh_cred0", 68'(dut.credit[0]), 68'd0);
    tx_valid = 1'b1; tx_vc = 1'b0; tx_last = 1'b1;
    #1 check("exh_ready0", 68'(tx_ready), 68'd0);
    tx_vc = 1'b1;
    #1 check("exh_ready1", 68'(tx_ready), 68'd1);
    tx_vc = 1'b0;
    @(posedge clk); #1;
    check("exh_noflit", channel_out, 68'd0);
    tx_valid = 1'b0;
    idle_cycle(2'b10);
    check("exh_ret_cred", 68'(dut.credit[0]), 68'd1);
    beat(62'h77, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1);
    check("exh_after_ret", channel_out, flit(1'b1, 1'b1, 1'b0, 2'b01, 62'h77));
    tx_vc = 1'b0;
    #1 check("exh_ready0_again", 68'(tx_ready), 68'd0);

    // Simultaneous send and return; overflow return on VC1
    for (int i = 0; i < 5; i++) idle_cycle(2'b10);
    check("sim_cred5", 68'(dut.credit[0]), 68'd5);
    beat(62'h55, 1'b1, 2'b00, 1'b0, 2'b10, 1'b1);
    check("sim_flit", channel_out, flit(1'b1, 1'b1, 1'b0, 2'b00, 62'h55));
    check("sim_cred_hold", 68'(dut.credit[0]), 68'd5);
    check("sim_err0", 68'(error), 68'd0);
    idle_cycle(2'b11);
    check("ovf_error", 68'(error), 68'd1);
    check("ovf_cred1", 68'(dut.credit[1]), 68'd8);

    // Overlong packet on VC1; returns paired with sends keep credit at 8
    do_reset();
    check("long_err_clr", 68'(error), 68'd0);
    for (int k = 1; k <= 9; k++) begin
      beat(62'(100 + k), 1'b0, 2'b01, 1'b1, 2'b11, 1'b1);
      if (k == 1 || k == 9) begin
        check("long_head", channel_out, flit(1'b1, 1'b0, 1'b1, 2'b01, 62'(100 + k)));
        check("long_busy_h", 68'(busy), 68'd1);
      end else if (k == 8) begin
        check("long_forced_tail", channel_out, flit(1'b0, 1'b1, 1'b1, 2'b00, 62'(100 + k)));
        check("long_error", 68'(error), 68'd1);
        check("long_busy_t", 68'(busy), 68'd0);
      end else begin
        check("long_body", channel_out, flit(1'b0, 1'b0, 1'b1, 2'b00, 62'(100 + k)));
        check("long_err_body", 68'(error), 68'd0);
      end
    end
    check("long_cred1", 68'(dut.credit[1]), 68'd8);
    beat(62'hEE, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1);
    check("long_close", channel_out, flit(1'b0, 1'b1, 1'b1, 2'b00, 62'hEE));

    // Reset in the middle of a packet
    do_reset();
    beat(62'hC0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1);
    beat(62'hC1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1);
    check("mid_body", channel_out, flit(1'b0, 1'b0, 1'b0, 2'b00, 62'hC1));
    reset = 1'b1;
    #1;
    check("mid_rst_chan", channel_out, 68'd0);
    check("mid_rst_busy", 68'(busy), 68'd0);
    check("mid_rst_cred0", 68'(dut.credit[0]), 68'd8);
    check("mid_rst_ready", 68'(tx_ready), 68'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    beat(62'hC2, 1'b0, 2'b01, 1'b1, 2'b00, 1'b1);
    check("mid_new_head", channel_out, flit(1'b1, 1'b0, 1'b1, 2'b01, 62'hC2));
    check("mid_new_busy", 68'(busy), 68'd1);
    idle_cycle(2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
